// File: rtl/n_term_loopback_switch_matrix_pkg.sv
// Shared definitions for the north-edge terminal switch matrix: config width,
// group-select encodings, group field offsets and config FSM states.
package n_term_loopback_switch_matrix_pkg;

  localparam int unsigned CFG_BITS = 10;

  localparam logic [1:0] SEL_REV      = 2'b00;
  localparam logic [1:0] SEL_STRAIGHT = 2'b01;
  localparam logic [1:0] SEL_ZERO     = 2'b10;
  localparam logic [1:0] SEL_ONE      = 2'b11;

  localparam int unsigned OFS_S1  = 0;
  localparam int unsigned OFS_S2  = 2;
  localparam int unsigned OFS_S2B = 4;
  localparam int unsigned OFS_S4  = 6;
  localparam int unsigned OFS_SS4 = 8;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    READY
  } cfg_state_e;

endpackage

// File: rtl/n_term_loopback_switch_matrix_term_group_mux.sv
// Per-group loopback mapper: reversed, straight, all-zero or all-one output
// selected by a 2-bit group select.
module term_group_mux
  import n_term_loopback_switch_matrix_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_in,
  input  logic [1:0]   i_sel,
  output logic [W-1:0] o_out
);

  always_comb begin
    o_out = '0;
    case (i_sel)
      SEL_REV: begin
        for (int unsigned i = 0; i < W; i++) begin
          o_out[i] = i_in[W-1-i];
        end
      end
      SEL_STRAIGHT: o_out = i_in;
      SEL_ZERO:     o_out = '0;
      default:      o_out = '1;
    endcase
  end

endmodule

// File: rtl/n_term_loopback_switch_matrix.sv
// North-edge terminal switch matrix with serially configured loopback mapping.
// Optional macro N_TERM_REG_OUT_EN registers all routing outputs.
module n_term_loopback_switch_matrix
  import n_term_loopback_switch_matrix_pkg::*;
#(
  parameter logic [1:0] RESET_MODE = 2'b00
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic [3:0]  N1END,
  input  logic [7:0]  N2MID,
  input  logic [7:0]  N2END,
  input  logic [15:0] N4END,
  input  logic [15:0] NN4END,
  output logic [3:0]  S1BEG,
  output logic [7:0]  S2BEG,
  output logic [7:0]  S2BEGb,
  output logic [15:0] S4BEG,
  output logic [15:0] SS4BEG,
  output logic        Co0,
  input  logic        cfg_in,
  input  logic        cfg_shift,
  input  logic        cfg_load,
  output logic        cfg_out,
  output logic        cfg_ready,
  output logic        cfg_err
);

  localparam logic [3:0] CNT_FULL = 4'(CFG_BITS);

  cfg_state_e          r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic [CFG_BITS-1:0] r_sr, w_sr_nxt;
  logic [CFG_BITS-1:0] r_active, w_active_nxt;
  logic                r_err, w_err_nxt;

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      r_state  <= EMPTY;
      r_cnt    <= '0;
      r_sr     <= '0;
      r_active <= {5{RESET_MODE}};
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sr     <= w_sr_nxt;
      r_active <= w_active_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // A load in READY wins over a simultaneous shift; a rejected load still lets the shift through.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sr_nxt     = r_sr;
    w_active_nxt = r_active;
    w_err_nxt    = 1'b0;
    case (r_state)
      READY: begin
        if (cfg_load) begin
          w_active_nxt = r_sr;
          w_cnt_nxt    = '0;
          w_state_nxt  = EMPTY;
        end else if (cfg_shift) begin
          w_sr_nxt = {r_sr[CFG_BITS-2:0], cfg_in};
        end
      end
      default: begin
        w_err_nxt = cfg_load;
        if (cfg_shift) begin
          w_sr_nxt    = {r_sr[CFG_BITS-2:0], cfg_in};
          w_cnt_nxt   = r_cnt + 4'd1;
          w_state_nxt = (r_cnt == CNT_FULL - 4'd1) ? READY : FILLING;
        end
      end
    endcase
  end

  assign cfg_out   = r_sr[CFG_BITS-1];
  assign cfg_ready = (r_cnt == CNT_FULL);
  assign cfg_err   = r_err;
  assign Co0       = 1'b0;

  logic [3:0]  w_s1;
  logic [7:0]  w_s2;
  logic [7:0]  w_s2b;
  logic [15:0] w_s4;
  logic [15:0] w_ss4;

  term_group_mux #(.W(4))  u_mux_s1  (.i_in(N1END),  .i_sel(r_active[OFS_S1  +: 2]), .o_out(w_s1));
  term_group_mux #(.W(8))  u_mux_s2  (.i_in(N2MID),  .i_sel(r_active[OFS_S2  +: 2]), .o_out(w_s2));
  term_group_mux #(.W(8))  u_mux_s2b (.i_in(N2END),  .i_sel(r_active[OFS_S2B +: 2]), .o_out(w_s2b));
  term_group_mux #(.W(16)) u_mux_s4  (.i_in(N4END),  .i_sel(r_active[OFS_S4  +: 2]), .o_out(w_s4));
  term_group_mux #(.W(16)) u_mux_ss4 (.i_in(NN4END), .i_sel(r_active[OFS_SS4 +: 2]), .o_out(w_ss4));

`ifdef N_TERM_REG_OUT_EN
  logic [3:0]  r_s1;
  logic [7:0]  r_s2;
  logic [7:0]  r_s2b;
  logic [15:0] r_s4;
  logic [15:0] r_ss4;

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_s2b <= '0;
      r_s4  <= '0;
      r_ss4 <= '0;
    end else begin
      r_s1  <= w_s1;
      r_s2  <= w_s2;
      r_s2b <= w_s2b;
      r_s4  <= w_s4;
      r_ss4 <= w_ss4;
    end
  end

  assign S1BEG  = r_s1;
  assign S2BEG  = r_s2;
  assign S2BEGb = r_s2b;
  assign S4BEG  = r_s4;
  assign SS4BEG = r_ss4;
`else
  assign S1BEG  = w_s1;
  assign S2BEG  = w_s2;
  assign S2BEGb = w_s2b;
  assign S4BEG  = w_s4;
  assign SS4BEG = w_ss4;
`endif

endmodule

// File: tb/tb_n_term_loopback_switch_matrix.sv
// Self-checking bench for n_term_loopback_switch_matrix against a behavioural
// model of the loopback mapping and configuration chain.
module tb_n_term_loopback_switch_matrix;

  localparam int TB_RESET_MODE = 0;

  logic        CLK = 1'b0;
  logic        resetn;
  logic [3:0]  N1END;
  logic [7:0]  N2MID;
  logic [7:0]  N2END;
  logic [15:0] N4END;
  logic [15:0] NN4END;
  logic [3:0]  S1BEG;
  logic [7:0]  S2BEG;
  logic [7:0]  S2BEGb;
  logic [15:0] S4BEG;
  logic [15:0] SS4BEG;
  logic        Co0;
  logic        cfg_in, cfg_shift, cfg_load;
  logic        cfg_out, cfg_ready, cfg_err;

  n_term_loopback_switch_matrix #(.RESET_MODE(2'b00)) dut (
    .CLK(CLK), .resetn(resetn),
    .N1END(N1END), .N2MID(N2MID), .N2END(N2END), .N4END(N4END), .NN4END(NN4END),
    .S1BEG(S1BEG), .S2BEG(S2BEG), .S2BEGb(S2BEGb), .S4BEG(S4BEG), .SS4BEG(SS4BEG),
    .Co0(Co0), .cfg_in(cfg_in), .cfg_shift(cfg_shift), .cfg_load(cfg_load),
    .cfg_out(cfg_out), .cfg_ready(cfg_ready), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Model state: per-group select values, shift register as an integer, bit count.
  int m_sel[5];
  int m_sr;
  int m_cnt;
  int m_err;
  int exp_now[5];
  int m_reg[5];
  int group_w[5] = '{4, 8, 8, 16, 16};

  function automatic int route(int in, int w, int sel);
    int r = 0;
    case (sel)
      0: for (int i = 0; i < w; i++) if (((in >> i) & 1) == 1) r = r | (1 << (w - 1 - i));
      1: r = in;
      2: r = 0;
      default: r = (1 << w) - 1;
    endcase
    return r;
  endfunction

  function automatic void calc_now();
    exp_now[0] = route(int'(N1END),  4,  m_sel[0]);
    exp_now[1] = route(int'(N2MID),  8,  m_sel[1]);
    exp_now[2] = route(int'(N2END),  8,  m_sel[2]);
    exp_now[3] = route(int'(N4END),  16, m_sel[3]);
    exp_now[4] = route(int'(NN4END), 16, m_sel[4]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_routes();
    N1END  = 4'($urandom);
    N2MID  = 8'($urandom);
    N2END  = 8'($urandom);
    N4END  = 16'($urandom);
    NN4END = 16'($urandom);
  endtask

  task automatic step();
    calc_now();
    @(posedge CLK);
    #1;
    if (!resetn) begin
      m_sr = 0; m_cnt = 0; m_err = 0;
      for (int g = 0; g < 5; g++) begin m_sel[g] = TB_RESET_MODE; m_reg[g] = 0; end
    end else begin
      for (int g = 0; g < 5; g++) m_reg[g] = exp_now[g];
      m_err = 0;
      if (cfg_load && m_cnt == 10) begin
        for (int g = 0; g < 5; g++) m_sel[g] = (m_sr >> (2 * g)) & 3;
        m_cnt = 0;
      end else begin
        if (cfg_load) m_err = 1;
        if (cfg_shift) begin
          m_sr  = ((m_sr * 2) + int'(cfg_in)) % 1024;
          m_cnt = (m_cnt < 10) ? m_cnt + 1 : 10;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int e[5];
    calc_now();
    for (int g = 0; g < 5; g++) begin
`ifdef N_TERM_REG_OUT_EN
      e[g] = m_reg[g];
`else
      e[g] = exp_now[g];
`endif
    end
    check({tag, ".S1BEG"},  32'(S1BEG),  32'(e[0]));
    check({tag, ".S2BEG"},  32'(S2BEG),  32'(e[1]));
    check({tag, ".S2BEGb"}, 32'(S2BEGb), 32'(e[2]));
    check({tag, ".S4BEG"},  32'(S4BEG),  32'(e[3]));
    check({tag, ".SS4BEG"}, 32'(SS4BEG), 32'(e[4]));
    check({tag, ".Co0"},    32'(Co0),    32'd0);
    check({tag, ".cfg_out"},   32'(cfg_out),   32'((m_sr >> 9) & 1));
    check({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(m_cnt == 10));
    check({tag, ".cfg_err"},   32'(cfg_err),   32'(m_err));
  endtask

  task automatic shift_bit(input logic b);
    cfg_shift = 1'b1;
    cfg_in    = b;
    randomize_routes();
    step();
    cfg_shift = 1'b0;
    check_all("shift");
  endtask

  task automatic do_load();
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    check_all("load");
  endtask

  initial begin
    resetn = 1'b0; cfg_in = 1'b0; cfg_shift = 1'b0; cfg_load = 1'b0;
    for (int g = 0; g < 5; g++) begin m_sel[g] = TB_RESET_MODE; m_reg[g] = 0; end
    m_sr = 0; m_cnt = 0; m_err = 0;
    randomize_routes();
    step();
    step();
    check_all("reset");

    // Reversed mapping straight out of reset.
    resetn = 1'b1;
    N4END = 16'h0001; N1END = 4'b0011;
`ifdef N_TERM_REG_OUT_EN
    step();
`endif
    #1;
    check("rst_rev_S4", 32'(S4BEG), 32'h8000);
    check("rst_rev_S1", 32'(S1BEG), 32'hC);
    check("rst_Co0", 32'(Co0), 32'd0);

    // Load 10'b0100000000: SS4 straight, others reversed.
    shift_bit(1'b0);
    shift_bit(1'b1);
    for (int i = 0; i < 8; i++) shift_bit(1'b0);
    check("full_ready", 32'(cfg_ready), 32'd1);
    do_load();
    NN4END = 16'h0003; N4END = 16'h0001;
`ifdef N_TERM_REG_OUT_EN
    step();
`endif
    #1;
    check("straight_SS4", 32'(SS4BEG), 32'h0003);
    check("still_rev_S4", 32'(S4BEG), 32'h8000);
    check("ready_dropped", 32'(cfg_ready), 32'd0);

    // Premature load after 4 shifts is rejected with a one-cycle error pulse.
    for (int i = 0; i < 4; i++) shift_bit(1'($urandom));
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    check("err_pulse", 32'(cfg_err), 32'd1);
    check_all("err_cycle");
    step();
    check("err_clear", 32'(cfg_err), 32'd0);
    check_all("after_err");
    for (int i = 0; i < 5; i++) shift_bit(1'($urandom));
    check("cnt9_not_ready", 32'(cfg_ready), 32'd0);
    shift_bit(1'($urandom));
    check("cnt10_ready", 32'(cfg_ready), 32'd1);

    // Simultaneous load and shift in READY commits pre-shift contents.
    cfg_load = 1'b1; cfg_shift = 1'b1; cfg_in = 1'b1;
    randomize_routes();
    step();
    cfg_load = 1'b0; cfg_shift = 1'b0;
    check_all("load_shift");
    check("load_shift_cnt0", 32'(cfg_ready), 32'd0);

    // 12 alternating shifts: first bit reaches cfg_out after the tenth.
    for (int i = 0; i < 12; i++) begin
      shift_bit(1'((i + 1) % 2));
      if (i == 9) check("cfg_out_first_bit", 32'(cfg_out), 32'd1);
      if (i >= 9) check("ready_saturates", 32'(cfg_ready), 32'd1);
    end
    do_load();

    // Randomized shift/load traffic.
    for (int n = 0; n < 300; n++) begin
      cfg_shift = 1'($urandom_range(0, 3) != 0);
      cfg_load  = 1'($urandom_range(0, 15) == 0);
      cfg_in    = 1'($urandom);
      randomize_routes();
      step();
      check_all("random");
    end
    cfg_shift = 1'b0; cfg_load = 1'b0;

    // Reset during a partial shift restores reversed mapping.
    resetn = 1'b0; step(); resetn = 1'b1;
    for (int i = 0; i < 10; i++) shift_bit(1'(i % 2));
    do_load();
    for (int i = 0; i < 6; i++) shift_bit(1'($urandom));
    resetn = 1'b0; cfg_shift = 1'b1;
    randomize_routes();
    step();
    check_all("mid_reset");
    check("mid_reset_ready", 32'(cfg_ready), 32'd0);
    resetn = 1'b1; cfg_shift = 1'b0;
    N1END = 4'b0001;
`ifdef N_TERM_REG_OUT_EN
    step();
`endif
    #1;
    check("post_reset_rev_S1", 32'(S1BEG), 32'h8);
    check_all("post_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
